// File: rtl/decode_stage_if.sv
// Fetch-to-execute bundle carried through decode_stage: fetch-side handshake,
// execute-side handshake and the decoded payload.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_alu_ctl;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_branch_c;
  logic            out_branch_uc;
  logic            out_branch_relative;
  logic            out_mem_read;
  logic            out_mem_write;
  logic            out_alu_pc;
  logic            out_alu_src;
  logic            out_reg_write;
  logic            out_data_out;
  logic            out_data_in;
  logic            out_illegal;

  // Environment side: fetch drives instructions, execute drives out_ready.
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_alu_ctl, out_rs1, out_rs2, out_rd,
           out_branch_c, out_branch_uc, out_branch_relative, out_mem_read, out_mem_write,
           out_alu_pc, out_alu_src, out_reg_write, out_data_out, out_data_in, out_illegal
  );

  // Decoder side.
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_alu_ctl, out_rs1, out_rs2, out_rd,
           out_branch_c, out_branch_uc, out_branch_relative, out_mem_read, out_mem_write,
           out_alu_pc, out_alu_src, out_reg_write, out_data_out, out_data_in, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Free-running instruction decode stage: combinational decode at the input,
// two-entry (output + skid) buffer so in_ready is purely registered.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b0
) (
  input logic           clk,
  input logic           rst,
  input logic           flush,
  decode_stage_if.slave bus
);

  typedef enum logic [4:0] {
    ALU_AND = 5'd0,  ALU_OR  = 5'd1,  ALU_ADD = 5'd2,  ALU_XOR = 5'd3,
    ALU_SLL = 5'd4,  ALU_SRL = 5'd5,  ALU_SUB = 5'd6,  ALU_LT  = 5'd7,
    ALU_GE  = 5'd8,  ALU_CHOOSEB = 5'd10, ALU_EQ = 5'd11, ALU_NE = 5'd12,
    ALU_LTU = 5'd13, ALU_GEU = 5'd14, ALU_SRA = 5'd15, ALU_MUL = 5'd16,
    ALU_ZERO = 5'd31
  } alu_op_e;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [4:0]      alu;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            branch_c;
    logic            branch_uc;
    logic            branch_rel;
    logic            mem_read;
    logic            mem_write;
    logic            alu_pc;
    logic            alu_src;
    logic            reg_write;
    logic            data_out;
    logic            data_in;
    logic            illegal;
  } bundle_t;

  localparam bundle_t RESET_B = '{alu: ALU_ZERO, branch_rel: 1'b1, default: '0};

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_OUT   = 7'b0000001;
  localparam logic [6:0] OP_IN    = 7'b0000000;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;
  logic [4:0]  base_alu;
  logic        legal;
  bundle_t     dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    base_alu = ALU_ADD;
    case (f3)
      3'b000: base_alu = ALU_ADD;
      3'b001: base_alu = ALU_SLL;
      3'b010: base_alu = ALU_LT;
      3'b011: base_alu = ALU_LTU;
      3'b100: base_alu = ALU_XOR;
      3'b101: base_alu = ALU_SRL;
      3'b110: base_alu = ALU_OR;
      3'b111: base_alu = ALU_AND;
      default: base_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    dec         = RESET_B;
    dec.pc      = bus.in_pc;
    dec.rs1     = instr[19:15];
    dec.rs2     = instr[24:20];
    dec.rd      = instr[11:7];
    dec.alu_src = 1'b1;
    legal       = 1'b1;
    imm32       = imm_i;
    case (opcode)
      OP_R: begin
        imm32         = '0;
        dec.alu_src   = 1'b0;
        dec.reg_write = 1'b1;
        case (f7)
          7'b0000000: dec.alu = base_alu;
          7'b0100000: begin
            if (f3 == 3'b000)      dec.alu = ALU_SUB;
            else if (f3 == 3'b101) dec.alu = ALU_SRA;
            else                   legal   = 1'b0;
          end
          7'b0000001: begin
            if (ENABLE_M) dec.alu = ALU_MUL + {2'b00, f3};
            else          legal   = 1'b0;
          end
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        dec.reg_write = 1'b1;
        dec.alu       = base_alu;
        // Shift-immediates reuse funct7 as an encoding qualifier.
        if (f3 == 3'b001 && f7 != 7'b0000000) legal = 1'b0;
        if (f3 == 3'b101) begin
          if (f7 == 7'b0100000)      dec.alu = ALU_SRA;
          else if (f7 != 7'b0000000) legal   = 1'b0;
        end
      end
      OP_LOAD: begin
        dec.alu       = ALU_ADD;
        dec.mem_read  = 1'b1;
        dec.reg_write = 1'b1;
        if (f3 != 3'b010) legal = 1'b0;
      end
      OP_JALR: begin
        dec.alu        = ALU_ADD;
        dec.branch_uc  = 1'b1;
        dec.branch_rel = 1'b0;
        dec.reg_write  = 1'b1;
        if (f3 != 3'b000) legal = 1'b0;
      end
      OP_S: begin
        imm32         = imm_s;
        dec.alu       = ALU_ADD;
        dec.mem_write = 1'b1;
        if (f3 != 3'b010) legal = 1'b0;
      end
      OP_B: begin
        imm32        = imm_b;
        dec.alu_src  = 1'b0;
        dec.branch_c = 1'b1;
        case (f3)
          3'b000:  dec.alu = ALU_EQ;
          3'b001:  dec.alu = ALU_NE;
          3'b100:  dec.alu = ALU_LT;
          3'b101:  dec.alu = ALU_GE;
          3'b110:  dec.alu = ALU_LTU;
          3'b111:  dec.alu = ALU_GEU;
          default: legal   = 1'b0;
        endcase
      end
      OP_JAL: begin
        imm32         = imm_j;
        dec.alu       = ALU_CHOOSEB;
        dec.branch_uc = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LUI: begin
        imm32         = imm_u;
        dec.alu       = ALU_ADD;
        dec.reg_write = 1'b1;
      end
      OP_AUIPC: begin
        imm32         = imm_u;
        dec.alu       = ALU_ADD;
        dec.alu_pc    = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_OUT: dec.data_out = 1'b1;
      OP_IN: begin
        dec.data_in   = 1'b1;
        dec.reg_write = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.illegal   = 1'b1;
      dec.alu       = ALU_ZERO;
      dec.reg_write = 1'b0;
      dec.mem_read  = 1'b0;
      dec.mem_write = 1'b0;
      dec.branch_c  = 1'b0;
      dec.branch_uc = 1'b0;
      dec.data_in   = 1'b0;
      dec.data_out  = 1'b0;
    end
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
    dec.imm = XLEN'($signed(imm32));
  end

  state_e  state_q, state_d;
  logic    in_ready_q, out_valid_q;
  bundle_t out_q, skid_q;
  logic    in_fire, out_fire;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (in_fire) state_d = S_ONE;
      S_ONE: begin
        if (in_fire && !out_fire)      state_d = S_FULL;
        else if (!in_fire && out_fire) state_d = S_EMPTY;
      end
      S_FULL:  if (out_fire) state_d = S_ONE;
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // Handshake flags are registered from the next state so in_ready never
  // depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= RESET_B;
      skid_q      <= RESET_B;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != S_FULL);
      out_valid_q <= (state_d != S_EMPTY);
      if (flush) begin
        out_q <= RESET_B;
      end else begin
        case (state_q)
          S_EMPTY: if (in_fire) out_q <= dec;
          S_ONE: begin
            if (in_fire && !out_fire)     skid_q <= dec;
            else if (in_fire && out_fire) out_q  <= dec;
          end
          S_FULL:  if (out_fire) out_q <= skid_q;
          default: ;
        endcase
      end
    end
  end

  assign bus.in_ready            = in_ready_q;
  assign bus.out_valid           = out_valid_q;
  assign bus.out_pc              = out_q.pc;
  assign bus.out_imm             = out_q.imm;
  assign bus.out_alu_ctl         = out_q.alu;
  assign bus.out_rs1             = out_q.rs1;
  assign bus.out_rs2             = out_q.rs2;
  assign bus.out_rd              = out_q.rd;
  assign bus.out_branch_c        = out_q.branch_c;
  assign bus.out_branch_uc       = out_q.branch_uc;
  assign bus.out_branch_relative = out_q.branch_rel;
  assign bus.out_mem_read        = out_q.mem_read;
  assign bus.out_mem_write       = out_q.mem_write;
  assign bus.out_alu_pc          = out_q.alu_pc;
  assign bus.out_alu_src         = out_q.alu_src;
  assign bus.out_reg_write       = out_q.reg_write;
  assign bus.out_data_out        = out_q.data_out;
  assign bus.out_data_in         = out_q.data_in;
  assign bus.out_illegal         = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a 32-bit RV32I-only instance and a 64-bit
// RV32M instance share stimulus; buffer corner cases run on the 32-bit one.
module tb_decode_stage;

  localparam logic [10:0] F_BC  = 11'h400, F_BUC = 11'h200, F_BR  = 11'h100;
  localparam logic [10:0] F_MR  = 11'h080, F_MW  = 11'h040, F_PC  = 11'h020;
  localparam logic [10:0] F_SRC = 11'h010, F_RW  = 11'h008, F_DO  = 11'h004;
  localparam logic [10:0] F_DI  = 11'h002, F_ILL = 11'h001;
  localparam logic [10:0] M_ALL = 11'h7FF;
  localparam logic [10:0] M_ILL = M_ALL & ~(F_BR | F_PC | F_SRC);
  localparam int NV = 17;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [4:0]  alu0, alu1;
    logic [10:0] fl0, fl1, mask;
    bit          chk_imm, chk_alu;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32)) bus32 ();
  decode_stage_if #(.XLEN(64)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.in_instr  = in_instr;
  assign bus32.in_pc     = in_pc;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_instr  = in_instr;
  assign bus64.in_pc     = {32'h0, in_pc};
  assign bus64.out_ready = out_ready;

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus32.slave));
  decode_stage #(.XLEN(64), .ENABLE_M(1'b1)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus64.slave));

  logic [10:0] fl32, fl64;
  assign fl32 = {bus32.out_branch_c, bus32.out_branch_uc, bus32.out_branch_relative,
                 bus32.out_mem_read, bus32.out_mem_write, bus32.out_alu_pc, bus32.out_alu_src,
                 bus32.out_reg_write, bus32.out_data_out, bus32.out_data_in, bus32.out_illegal};
  assign fl64 = {bus64.out_branch_c, bus64.out_branch_uc, bus64.out_branch_relative,
                 bus64.out_mem_read, bus64.out_mem_write, bus64.out_alu_pc, bus64.out_alu_src,
                 bus64.out_reg_write, bus64.out_data_out, bus64.out_data_in, bus64.out_illegal};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid32"}, bus32.out_valid, 0);
    check({tag, " ready32"}, bus32.in_ready, 1);
    check({tag, " alu32"}, bus32.out_alu_ctl, 31);
    check({tag, " flags32"}, fl32, F_BR);
    check({tag, " imm32"}, bus32.out_imm, 0);
    check({tag, " pc32"}, bus32.out_pc, 0);
    check({tag, " regs32"}, {bus32.out_rs1, bus32.out_rs2, bus32.out_rd}, 0);
    check({tag, " valid64"}, bus64.out_valid, 0);
    check({tag, " alu64_flags64"}, {bus64.out_alu_ctl, fl64}, {5'd31, F_BR});
  endtask

  task automatic fill_two();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00500093; in_pc = 32'h300; step();
    in_instr  = 32'h402081B3; in_pc = 32'h304; step();
    in_valid  = 1'b0;
  endtask

  vec_t        tbl[NV];
  logic [31:0] bp_instr[3];
  logic [31:0] bp_pc[3];
  logic [31:0] got[$];
  int          acc;
  int          seen;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            instr         imm                    alu0 alu1 fl0                   fl1                   mask   imm alu
    tbl[0]  = '{32'h00500093, 64'h5,                 2,  2,  F_BR|F_SRC|F_RW,      F_BR|F_SRC|F_RW,      M_ALL, 1, 1};
    tbl[1]  = '{32'h402081B3, 64'h0,                 6,  6,  F_BR|F_RW,            F_BR|F_RW,            M_ALL, 0, 1};
    tbl[2]  = '{32'h123452B7, 64'h12345000,          2,  2,  F_BR|F_SRC|F_RW,      F_BR|F_SRC|F_RW,      M_ALL, 1, 1};
    tbl[3]  = '{32'h008000EF, 64'h8,                 10, 10, F_BUC|F_BR|F_SRC|F_RW, F_BUC|F_BR|F_SRC|F_RW, M_ALL, 1, 1};
    tbl[4]  = '{32'hFE208EE3, 64'hFFFFFFFFFFFFFFFC,  11, 11, F_BC|F_BR,            F_BC|F_BR,            M_ALL, 1, 1};
    tbl[5]  = '{32'h0020A423, 64'h8,                 2,  2,  F_BR|F_SRC|F_MW,      F_BR|F_SRC|F_MW,      M_ALL, 1, 1};
    tbl[6]  = '{32'h800000B7, 64'hFFFFFFFF80000000,  2,  2,  F_BR|F_SRC|F_RW,      F_BR|F_SRC|F_RW,      M_ALL, 1, 1};
    tbl[7]  = '{32'h022081B3, 64'h0,                 31, 16, F_ILL,                F_BR|F_RW,            M_ILL, 0, 1};
    tbl[8]  = '{32'h00010083, 64'h0,                 31, 31, F_ILL,                F_ILL,                M_ILL, 0, 1};
    tbl[9]  = '{32'h00208033, 64'h0,                 2,  2,  F_BR,                 F_BR,                 M_ALL, 0, 1};
    tbl[10] = '{32'h00008067, 64'h0,                 2,  2,  F_BUC|F_SRC,          F_BUC|F_SRC,          M_ALL, 1, 1};
    tbl[11] = '{32'h00001397, 64'h1000,              2,  2,  F_BR|F_PC|F_SRC|F_RW, F_BR|F_PC|F_SRC|F_RW, M_ALL, 1, 1};
    tbl[12] = '{32'h4030D213, 64'h403,               15, 15, F_BR|F_SRC|F_RW,      F_BR|F_SRC|F_RW,      M_ALL, 1, 1};
    tbl[13] = '{32'h0020E863, 64'h10,                13, 13, F_BC|F_BR,            F_BC|F_BR,            M_ALL, 1, 1};
    tbl[14] = '{32'h0000007F, 64'h0,                 31, 31, F_ILL,                F_ILL,                M_ILL, 0, 1};
    tbl[15] = '{32'h00000080, 64'h0,                 0,  0,  F_DI|F_RW|F_SRC|F_BR, F_DI|F_RW|F_SRC|F_BR, M_ALL, 0, 0};
    tbl[16] = '{32'h00008001, 64'h0,                 0,  0,  F_DO|F_SRC|F_BR,      F_DO|F_SRC|F_BR,      M_ALL, 0, 0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    repeat (3) step();
    rst = 1'b0;
    check_reset_outputs("reset");

    // Back-to-back stream: each bundle visible right after its accepting edge.
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = tbl[i].instr;
      in_pc    = 32'h100 + 32'(4 * i);
      check($sformatf("v%0d ready", i), {bus32.in_ready, bus64.in_ready}, 2'b11);
      step();
      check($sformatf("v%0d valid", i), {bus32.out_valid, bus64.out_valid}, 2'b11);
      check($sformatf("v%0d pc32", i), bus32.out_pc, in_pc);
      check($sformatf("v%0d pc64", i), bus64.out_pc, {32'h0, in_pc});
      check($sformatf("v%0d regs", i), {bus32.out_rs1, bus32.out_rs2, bus32.out_rd},
            {tbl[i].instr[19:15], tbl[i].instr[24:20], tbl[i].instr[11:7]});
      check($sformatf("v%0d flags32", i), fl32 & tbl[i].mask, tbl[i].fl0 & tbl[i].mask);
      check($sformatf("v%0d flags64", i), fl64 & tbl[i].mask, tbl[i].fl1 & tbl[i].mask);
      if (tbl[i].chk_alu) begin
        check($sformatf("v%0d alu32", i), bus32.out_alu_ctl, tbl[i].alu0);
        check($sformatf("v%0d alu64", i), bus64.out_alu_ctl, tbl[i].alu1);
      end
      if (tbl[i].chk_imm) begin
        check($sformatf("v%0d imm32", i), bus32.out_imm, tbl[i].imm[31:0]);
        check($sformatf("v%0d imm64", i), bus64.out_imm, tbl[i].imm);
      end
    end
    in_valid = 1'b0;
    step();
    check("drain valid", bus32.out_valid, 0);

    // Backpressure: three offered while stalled, only two may be taken.
    bp_instr[0] = 32'h00500093; bp_pc[0] = 32'h200;
    bp_instr[1] = 32'h402081B3; bp_pc[1] = 32'h204;
    bp_instr[2] = 32'h123452B7; bp_pc[2] = 32'h208;
    acc = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_instr = bp_instr[acc];
      in_pc    = bp_pc[acc];
      if (bus32.in_ready) acc++;
      step();
      check($sformatf("bp hold pc %0d", k), bus32.out_pc, 32'h200);
      check($sformatf("bp hold valid %0d", k), bus32.out_valid, 1);
      check($sformatf("bp hold ctl %0d", k), {bus32.out_alu_ctl, fl32, bus32.out_imm},
            {5'd2, F_BR | F_SRC | F_RW, 32'd5});
      if (k >= 1) check($sformatf("bp ready low %0d", k), bus32.in_ready, 0);
    end
    check("bp accepted while stalled", acc, 2);
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (acc < 3) begin
        in_valid = 1'b1;
        in_instr = bp_instr[acc];
        in_pc    = bp_pc[acc];
      end else begin
        in_valid = 1'b0;
      end
      if (in_valid && bus32.in_ready) acc++;
      if (bus32.out_valid) got.push_back(bus32.out_pc);
      step();
    end
    check("bp accepted total", acc, 3);
    check("bp delivered count", got.size(), 3);
    for (int j = 0; j < got.size() && j < 3; j++)
      check($sformatf("bp order %0d", j), got[j], bp_pc[j]);
    check("bp drained", bus32.out_valid, 0);

    // Flush while FULL.
    fill_two();
    check("full ready low", bus32.in_ready, 0);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700393; in_pc = 32'h3F0;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush full valid", bus32.out_valid, 0);
    check("flush full ready", bus32.in_ready, 1);
    seen = 0;
    repeat (3) begin step(); if (bus32.out_valid) seen++; end
    check("flush full nothing delivered", seen, 0);

    // Flush while ONE with in_ready high: the offered instruction must vanish.
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h400;
    step();
    check("one state valid", bus32.out_valid, 1);
    flush = 1'b1; in_instr = 32'h00700393; in_pc = 32'h404;
    check("one ready before flush", bus32.in_ready, 1);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("flush one valid", bus32.out_valid, 0);
    check("flush one ready", bus32.in_ready, 1);
    seen = 0;
    repeat (3) begin step(); if (bus32.out_valid) seen++; end
    check("flush one nothing delivered", seen, 0);

    // Reset mid-stream while FULL.
    fill_two();
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h123452B7; in_pc = 32'h308;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_reset_outputs("midrst");
    out_ready = 1'b1;
    seen = 0;
    repeat (3) begin step(); if (bus32.out_valid) seen++; end
    check("midrst nothing delivered", seen, 0);

    // Recovery after flush/reset.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h500;
    step();
    in_valid = 1'b0;
    check("recover valid", bus32.out_valid, 1);
    check("recover pc", bus32.out_pc, 32'h500);
    check("recover imm", bus32.out_imm, 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
